// File: rtl/iob_dir_sched_if.sv
// ---------------------------------------------------------------------------
// iob_dir_sched_if
// Bundles the handshake and pad-side signals of the IOBUF direction scheduler.
//   tx_valid/tx_data/tx_last/tx_ready : transmit beat handshake
//   rx_req                            : level request for a receive window
//   rx_valid/rx_data                  : sampled pad value stream
//   pad_i                             : from IOBUF O
//   pad_o/pad_t                       : to IOBUF I / T (pad_t=1 is high-Z)
//   ibufdisable/intermdisable         : to IOBUF IBUFDISABLE / INTERMDISABLE
//   state_o                           : scheduler state, for debug
// Modport slave is the scheduler; master is the fabric/pad side around it.
// ---------------------------------------------------------------------------
interface iob_dir_sched_if;
  logic       tx_valid;
  logic       tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_req;
  logic       rx_valid;
  logic       rx_data;
  logic       pad_i;
  logic       pad_o;
  logic       pad_t;
  logic       ibufdisable;
  logic       intermdisable;
  logic [2:0] state_o;

  modport slave (
    input  tx_valid, tx_data, tx_last, rx_req, pad_i,
    output tx_ready, rx_valid, rx_data, pad_o, pad_t,
           ibufdisable, intermdisable, state_o
  );

  modport master (
    output tx_valid, tx_data, tx_last, rx_req, pad_i,
    input  tx_ready, rx_valid, rx_data, pad_o, pad_t,
           ibufdisable, intermdisable, state_o
  );
endinterface

// File: rtl/iob_dir_sched.sv
// ---------------------------------------------------------------------------
// iob_dir_sched
// Direction scheduler for one shared bidirectional pad (IOBUF_INTERMDISABLE).
// Arbitrates between a transmit requester and a receive requester, inserting
// a turnaround window before driving and an input-settle window before
// sampling. Ties are broken round-robin; a grant is forcibly released after
// HOLD_MAX beats/cycles while the other side is waiting.
//
// Parameters:
//   TURN_CYCLES : turnaround / settle window length, 1..15
//   HOLD_MAX    : max beats (TX) or cycles (RX) per contended grant, 1..255
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   io (slave)  : handshake and pad signals, see iob_dir_sched_if
// Build option:
//   IOB_DIR_SCHED_RX_SYNC_EN : when defined, pad_i goes through a 2-flop
//   synchronizer (rx latency 2); otherwise a single capture flop (latency 1).
// ---------------------------------------------------------------------------
module iob_dir_sched #(
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_MAX    = 16
) (
  input  logic            clk,
  input  logic            rst,
  iob_dir_sched_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_TURN = 3'd1,
    TX      = 3'd2,
    RX_TURN = 3'd3,
    RX      = 3'd4
  } state_e;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       last_rx_q, last_rx_d;   // 1: the most recent grant went to RX
  logic       pad_o_q, pad_o_d;
  logic [7:0] hold_inc;
  logic       hold_hit;

  logic       rx_smp_p0_q, rx_smp_p0_d;
  logic       vld_p0_q, vld_p0_d;
`ifdef IOB_DIR_SCHED_RX_SYNC_EN
  logic       rx_smp_p1_q, rx_smp_p1_d;
  logic       vld_p1_q, vld_p1_d;
`endif

  always_comb begin
    // Saturating increment; hold_hit flags that the beat/cycle counted now
    // is the HOLD_MAX-th (or later) of this grant.
    hold_inc = (hold_cnt_q == HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 8'd1;
    hold_hit = (hold_cnt_q >= (HOLD_LIM - 8'd1));

    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    hold_cnt_d = hold_cnt_q;
    last_rx_d  = last_rx_q;
    pad_o_d    = pad_o_q;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time is granted.
        if (io.tx_valid && (!io.rx_req || last_rx_q)) begin
          state_d    = TX_TURN;
          turn_cnt_d = '0;
          last_rx_d  = 1'b0;
        end else if (io.rx_req) begin
          state_d    = RX_TURN;
          turn_cnt_d = '0;
          last_rx_d  = 1'b1;
        end
      end
      TX_TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = TX;
          hold_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
      TX: begin
        // A cycle without tx_valid is a stall: nothing moves.
        if (io.tx_valid) begin
          pad_o_d    = io.tx_data;
          hold_cnt_d = hold_inc;
          if (io.tx_last || (hold_hit && io.rx_req)) begin
            state_d = IDLE;
          end
        end
      end
      RX_TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = RX;
          hold_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
      RX: begin
        hold_cnt_d = hold_inc;
        if (!io.rx_req || (hold_hit && io.tx_valid)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Receive pipeline: a sample is valid only if captured during RX.
    rx_smp_p0_d = io.pad_i;
    vld_p0_d    = (state_q == RX);
`ifdef IOB_DIR_SCHED_RX_SYNC_EN
    rx_smp_p1_d = rx_smp_p0_q;
    vld_p1_d    = vld_p0_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      turn_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      last_rx_q   <= 1'b1;
      pad_o_q     <= 1'b0;
      rx_smp_p0_q <= 1'b0;
      vld_p0_q    <= 1'b0;
`ifdef IOB_DIR_SCHED_RX_SYNC_EN
      rx_smp_p1_q <= 1'b0;
      vld_p1_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_rx_q   <= last_rx_d;
      pad_o_q     <= pad_o_d;
      // ---- stage p0: pad capture ----
      rx_smp_p0_q <= rx_smp_p0_d;
      vld_p0_q    <= vld_p0_d;
`ifdef IOB_DIR_SCHED_RX_SYNC_EN
      // ---- stage p1: second synchronizer flop ----
      rx_smp_p1_q <= rx_smp_p1_d;
      vld_p1_q    <= vld_p1_d;
`endif
    end
  end

  // Pad controls decode from the state register alone, so an asynchronous
  // reset releases the pad immediately.
  assign io.state_o       = state_q;
  assign io.pad_t         = (state_q != TX);
  assign io.tx_ready      = (state_q == TX);
  assign io.ibufdisable   = !((state_q == RX_TURN) || (state_q == RX));
  assign io.intermdisable = !((state_q == RX_TURN) || (state_q == RX));
  assign io.pad_o         = pad_o_q;
`ifdef IOB_DIR_SCHED_RX_SYNC_EN
  assign io.rx_data       = rx_smp_p1_q;
  assign io.rx_valid      = vld_p1_q;
`else
  assign io.rx_data       = rx_smp_p0_q;
  assign io.rx_valid      = vld_p0_q;
`endif

endmodule

// File: doc/iob_dir_sched.md
# iob_dir_sched

Direction scheduler for one shared bidirectional pad implemented with an `IOBUF_INTERMDISABLE` primitive. It arbitrates between a transmit requester and a receive requester, and inserts turnaround and input-settle windows between them. It drives the primitive's `I`, `T`, `IBUFDISABLE` and `INTERMDISABLE` pins, and samples its `O` pin. The block sits inside the ROI, between the fabric logic fed from the `din`/`dout` shift harness and the pad primitive.

## Interface
Parameters:
- `TURN_CYCLES`, default 2: turnaround/settle window length in cycles; legal range 1..15 (4-bit counter).
- `HOLD_MAX`, default 16: maximum beats or cycles per grant when the other side is requesting; legal range 1..255 (8-bit counter).

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `tx_valid`  in  1: transmit beat offered.
- `tx_data`  in  1: transmit bit.
- `tx_last`  in  1: final beat of the transmit burst.
- `tx_ready`  out  1: beat accepted this cycle when `tx_valid & tx_ready`.
- `rx_req`  in  1: level request for a receive window.
- `rx_valid`  out  1: `rx_data` holds a pad sample.
- `rx_data`  out  1: sampled pad value.
- `pad_i`  in  1: from IOBUF `O`.
- `pad_o`  out  1: to IOBUF `I`.
- `pad_t`  out  1: to IOBUF `T`; 1 = high-Z.
- `ibufdisable`  out  1: to IOBUF `IBUFDISABLE`.
- `intermdisable`  out  1: to IOBUF `INTERMDISABLE`.
- `state_o`  out  3: current state encoding, for debug.

## Operation
States and encodings: IDLE=0, TX_TURN=1, TX=2, RX_TURN=3, RX=4. All outputs are registered, or decoded from the state register only.

- **IDLE:** `pad_t`=1, `ibufdisable`=1, `intermdisable`=1, `tx_ready`=0.
  - Request is `tx_valid` (TX) or `rx_req` (RX).
  - If only one side requests, that side is granted.
  - If both request, the side not granted last is granted. `last_grant` resets to RX, so TX wins the first tie.
- **TX_TURN:** `pad_t`=1 for exactly `TURN_CYCLES` cycles, then go to TX. Input buffers stay disabled.
- **TX:** `pad_t`=0 and `tx_ready`=1.
  - Each accepted beat registers `pad_o <= tx_data`.
  - Exit to IDLE after accepting a beat with `tx_last`=1.
  - Also exit after the `HOLD_MAX`-th accepted beat, but only while `rx_req`=1 (forced release).
  - `tx_valid`=0 inside TX holds the state and holds `pad_o`; it does not count as a beat.
- **RX_TURN:** `ibufdisable`=0, `intermdisable`=0, `pad_t`=1 for `TURN_CYCLES` cycles (input settle), then go to RX.
- **RX:** inputs stay enabled and `pad_i` is sampled every cycle.
  - Exit to IDLE when `rx_req`=0.
  - Also exit after `HOLD_MAX` RX cycles, but only while `tx_valid`=1.
- **Counters:** the hold counter clears on entry to TX/RX and saturates at `HOLD_MAX`. The turn counter clears on entry to each TURN state.
- **IDLE dwell:** every return to IDLE spends at least one IDLE cycle, with `pad_t`=1 and inputs disabled, before the next grant.
- **Receive pipeline:** `rx_valid` is pipelined alongside `rx_data`. It is 1 only for samples captured while in RX. The pipeline drains after RX exits.

## Timing
- **Reset values:** `pad_t`=1, `pad_o`=0, `ibufdisable`=1, `intermdisable`=1, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `state_o`=0, `last_grant`=RX.
- **Reset mid-operation:** outputs take reset values immediately, without waiting for a clock edge. The pad is released in the same cycle.
- **Grant latency:** request seen in IDLE at edge N → TX_TURN/RX_TURN from N+1 → TX/RX from N+1+`TURN_CYCLES`.
- **`pad_o` timing:** updates one edge after an accepted beat. `pad_t`=0 from the first TX cycle.
- **`rx_data` latency:** `pad_i` → `rx_data` is 1 cycle (2 with sync enabled).
- **Simultaneous events:**
  - `tx_last` on the `HOLD_MAX`-th beat is a single exit.
  - `rx_req` falling on the `HOLD_MAX`-th cycle is a single exit.
  - A request arriving in the exit cycle is arbitrated from IDLE on the next edge.

## Configuration
- `IOB_DIR_SCHED_RX_SYNC_EN` defined: `pad_i` passes through a 2-flop synchronizer. `rx_data`/`rx_valid` latency is 2 cycles, and the pipeline drains 2 cycles after RX exits.
- Macro undefined: `pad_i` uses a single capture register, with latency 1.

## Test plan
All scenarios use `TURN_CYCLES`=2 and `HOLD_MAX`=4, with sync off unless stated.
- **Reset:** assert `rst` asynchronously mid-TX (`pad_t`=0) → `pad_t`=1, `ibufdisable`=1, `state_o`=0 before the next edge. After release, the block stays in IDLE.
- **Lone TX:** 3-beat burst 1,0,1 with `tx_last` on beat 3, requested at edge 0 → `pad_t`=0 at edges 3–5, `pad_o` sequence 1,0,1, IDLE at edge 6, `pad_t`=1.
- **Lone RX:** `rx_req` held for 5 RX cycles while `pad_i` toggles 1,0,1,1,0 → `ibufdisable`=0 from edge 1, `rx_valid`=1 for exactly 5 cycles, `rx_data` matches the input one cycle later.
- **Tie and round-robin:** `tx_valid`=1 and `rx_req`=1 from reset → TX granted first. A forced release after 4 beats, then one IDLE cycle, then RX_TURN. RX is forced out after 4 cycles and TX regains the grant.
- **Stall:** `tx_valid` drops for 3 cycles inside TX → `tx_ready` stays 1, `pad_o` holds, no beat is counted and no exit occurs.
- **Sync build:** with `IOB_DIR_SCHED_RX_SYNC_EN` defined → `rx_data` lags `pad_i` by 2 cycles, and the final `rx_valid` falls 2 cycles after `rx_req` drops.
